// File: rtl/stream_slice_serializer.sv
// stream_slice_serializer: clocked left/right streaming concatenation, one slice per cycle
module stream_slice_serializer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_left,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  localparam int NSLICE = (WIDTH + SLICE - 1) / SLICE;
  localparam int REM = WIDTH - (NSLICE - 1) * SLICE;
  // SL clamps the shift so an oversized SLICE never indexes past the operand
  localparam int SL = SLICE < WIDTH ? SLICE : WIDTH;
  localparam int CW = $clog2(NSLICE) + 1;
  localparam logic [WIDTH-1:0] MS = {WIDTH{1'b1}} >> (WIDTH - SL);
  localparam logic [WIDTH-1:0] MR = {WIDTH{1'b1}} >> (WIDTH - REM);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] sr, acc, fin;
  logic [CW-1:0] cnt;
  logic lft;
  assign in_ready = state == IDLE;
  assign busy = state == BUSY;
  assign out_valid = state == DONE;
  assign fin = (acc << REM) | (sr & MR);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      acc <= '0;
      cnt <= '0;
      lft <= 1'b0;
      out_data <= '0;
    end else if (state == IDLE && in_valid) begin
      sr <= in_data;
      lft <= in_left;
      acc <= '0;
      cnt <= '0;
      state <= BUSY;
    end else if (state == BUSY && cnt == CW'(NSLICE - 1)) begin
      acc <= fin;
      out_data <= lft ? fin : sr;
      state <= DONE;
    end else if (state == BUSY) begin
      acc <= (acc << SL) | (sr & MS);
      sr <= lft ? sr >> SL : sr;
      cnt <= cnt + 1'b1;
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_stream_slice_serializer.sv
// tb_stream_slice_serializer: scoreboard bench over several WIDTH/SLICE configurations
module tb_stream_slice_serializer;
  localparam int N = 11;
  localparam int WS [N] = '{4, 4, 4, 4, 4, 32, 23, 23, 37, 96, 1};
  localparam int SS [N] = '{1, 2, 3, 4, 5, 1, 3, 4, 4, 1, 1};
  localparam logic [127:0] DX [N] = '{128'h1, 128'h1, 128'h1, 128'h1, 128'h1, 128'h04030201,
    128'h020301, 128'h020301, 128'h0504030201, 128'h1, 128'h1};
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] iv = '0, il = '0, ordy = '0;
  wire logic [N-1:0] ir, ov, bz;
  logic [127:0] din [N];
  wire logic [127:0] od [N];
  int vectors = 0, miscompares = 0, cyc = 0;
  logic [127:0] sb [$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < N; g++) begin : d
    logic [WS[g]-1:0] o;
    stream_slice_serializer #(.WIDTH(WS[g]), .SLICE(SS[g])) u (
      .clk(clk), .rst(rst), .in_valid(iv[g]), .in_ready(ir[g]), .in_data(din[g][WS[g]-1:0]),
      .in_left(il[g]), .out_valid(ov[g]), .out_ready(ordy[g]), .out_data(o), .busy(bz[g]));
    assign od[g] = 128'(o);
  end
  function automatic int ns(input int i);
    return (WS[i] + SS[i] - 1) / SS[i];
  endfunction
  function automatic logic [127:0] msk(input int w);
    return (128'd1 << w) - 128'd1;
  endfunction
  // slice k of the operand lands directly below slice k-1, starting at the MSB
  function automatic logic [127:0] model(input logic [127:0] x, input int w, input int s, input logic left);
    logic [127:0] r;
    int k, len, dst;
    r = '0;
    if (!left) return x & msk(w);
    for (int b = 0; b < w; b++) begin
      k = b / s;
      len = (w - k * s < s) ? w - k * s : s;
      dst = w - k * s - len + b % s;
      r[dst] = x[b];
    end
    return r;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic op(input int i, input logic [127:0] x, input logic left);
    int n;
    logic [127:0] e;
    n = 0;
    while (!ir[i] && n < 50) begin tick; n++; end
    vectors++;
    if (ir[i] !== 1'b1) begin miscompares++; $display("FAIL ready_wait[%0d]: in_ready=%b want 1", i, ir[i]); end
    din[i] = x & msk(WS[i]);
    il[i] = left;
    iv[i] = 1'b1;
    tick;
    iv[i] = 1'b0;
    sb.push_back(model(x, WS[i], SS[i], left));
    n = 0;
    while (!ov[i] && n < 300) begin tick; n++; end
    vectors++;
    if (n !== ns(i)) begin miscompares++; $display("FAIL latency[%0d]: %0d cycles want %0d", i, n, ns(i)); end
    e = sb.pop_front();
    vectors++;
    if (od[i] !== e) begin miscompares++; $display("FAIL data[%0d] left=%b x=%h: got %h want %h", i, left, x, od[i], e); end
    ordy[i] = 1'b1;
    tick;
    ordy[i] = 1'b0;
    vectors++;
    if (ov[i] !== 1'b0 || ir[i] !== 1'b1) begin miscompares++; $display("FAIL release[%0d]: out_valid=%b in_ready=%b want 0 1", i, ov[i], ir[i]); end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      vectors++;
      if ({ov[i], ir[i], bz[i]} !== 3'b010 || od[i] !== '0) begin
        miscompares++;
        $display("FAIL reset[%0d]: valid/ready/busy=%b data=%h want 010 0", i, {ov[i], ir[i], bz[i]}, od[i]);
      end
    end
  endtask
  task automatic test_directed;
    for (int i = 0; i < N; i++) begin
      op(i, DX[i], 1'b1);
      op(i, DX[i], 1'b0);
    end
  endtask
  task automatic test_random;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) op(i, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(1)));
  endtask
  task automatic test_backpressure;
    int n;
    logic [127:0] x, y, e;
    x = {96'h0, $urandom};
    y = {96'h0, $urandom};
    din[5] = x;
    il[5] = 1'b1;
    iv[5] = 1'b1;
    tick;
    sb.push_back(model(x, 32, 1, 1'b1));
    din[5] = ~x & msk(32);
    tick;
    tick;
    iv[5] = 1'b0;
    n = 0;
    while (!ov[5] && n < 100) begin tick; n++; end
    e = sb.pop_front();
    vectors++;
    if (od[5] !== e) begin miscompares++; $display("FAIL bp_data: got %h want %h", od[5], e); end
    for (int k = 0; k < 5; k++) begin
      tick;
      vectors++;
      if (ov[5] !== 1'b1 || ir[5] !== 1'b0 || od[5] !== e) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b data=%h want 1 0 %h", k, ov[5], ir[5], od[5], e);
      end
    end
    din[5] = y;
    il[5] = 1'b0;
    iv[5] = 1'b1;
    ordy[5] = 1'b1;
    tick;
    ordy[5] = 1'b0;
    vectors++;
    if (ov[5] !== 1'b0 || ir[5] !== 1'b1) begin miscompares++; $display("FAIL bp_idle: valid=%b ready=%b want 0 1", ov[5], ir[5]); end
    tick;
    iv[5] = 1'b0;
    sb.push_back(y);
    vectors++;
    if (bz[5] !== 1'b1) begin miscompares++; $display("FAIL bp_accept: busy=%b want 1", bz[5]); end
    n = 0;
    while (!ov[5] && n < 100) begin tick; n++; end
    e = sb.pop_front();
    vectors++;
    if (od[5] !== e) begin miscompares++; $display("FAIL bp_next: got %h want %h", od[5], e); end
    ordy[5] = 1'b1;
    tick;
    ordy[5] = 1'b0;
  endtask
  task automatic test_reset_busy;
    int n;
    logic [127:0] e;
    din[5] = 128'h89abcdef;
    il[5] = 1'b1;
    iv[5] = 1'b1;
    tick;
    iv[5] = 1'b0;
    tick;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    vectors++;
    if (ov[5] !== 1'b0 || ir[5] !== 1'b1 || od[5] !== '0) begin
      miscompares++;
      $display("FAIL rst_busy: valid=%b ready=%b data=%h want 0 1 0", ov[5], ir[5], od[5]);
    end
    n = 0;
    for (int k = 0; k < 40; k++) begin tick; n += int'(ov[5]); end
    vectors++;
    if (n !== 0) begin miscompares++; $display("FAIL rst_ghost: %0d valid cycles want 0", n); end
    din[5] = 128'h13572468;
    iv[5] = 1'b1;
    tick;
    iv[5] = 1'b0;
    sb.push_back(model(128'h13572468, 32, 1, 1'b1));
    n = 0;
    while (!ov[5] && n < 100) begin tick; n++; end
    e = sb.pop_front();
    vectors++;
    if (od[5] !== e) begin miscompares++; $display("FAIL rst_pre: got %h want %h", od[5], e); end
    rst = 1'b1;
    ordy[5] = 1'b1;
    tick;
    rst = 1'b0;
    ordy[5] = 1'b0;
    vectors++;
    if (od[5] !== '0 || ov[5] !== 1'b0) begin miscompares++; $display("FAIL rst_done: data=%h valid=%b want 0 0", od[5], ov[5]); end
  endtask
  task automatic test_back_to_back;
    int n, a, prev;
    logic [127:0] x, e;
    prev = 0;
    ordy[6] = 1'b1;
    iv[6] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      x = {96'h0, $urandom} & msk(23);
      din[6] = x;
      il[6] = (k != 1);
      n = 0;
      while (!ir[6] && n < 50) begin tick; n++; end
      tick;
      a = cyc;
      sb.push_back(model(x, 23, 3, k != 1));
      if (k > 0) begin
        vectors++;
        if (a - prev !== ns(6) + 2) begin miscompares++; $display("FAIL b2b_interval[%0d]: %0d want %0d", k, a - prev, ns(6) + 2); end
      end
      prev = a;
      n = 0;
      while (!ov[6] && n < 100) begin tick; n++; end
      e = sb.pop_front();
      vectors++;
      if (od[6] !== e) begin miscompares++; $display("FAIL b2b_data[%0d]: got %h want %h", k, od[6], e); end
    end
    iv[6] = 1'b0;
    tick;
    ordy[6] = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < N; i++) din[i] = '0;
    test_reset;
    test_directed;
    test_random;
    test_backpressure;
    test_reset_busy;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
